// File: rtl/hilo_divider_pkg.sv
// Shared CPU definitions for the HI/LO divider: FSM state encodings and default width.
package hilo_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 32;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One restoring-division iteration: shift {remainder, quotient} left, trial-subtract, restore or keep.
module hilo_divider_div_step
    import hilo_divider_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEFAULT
) (
    input  logic [width-1:0] rem,
    input  logic [width-1:0] quo,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] rem_next,
    output logic [width-1:0] quo_next
);

    logic [width:0] shifted;
    logic [width:0] diff;

    always_comb begin
        shifted  = {rem, quo[width-1]};
        diff     = shifted - {1'b0, divisor};
        // Borrow out of the width+1-bit subtract means the trial went negative.
        if (!diff[width]) begin
            rem_next = diff[width-1:0];
            quo_next = {quo[width-2:0], 1'b1};
        end else begin
            rem_next = shifted[width-1:0];
            quo_next = {quo[width-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU; one quotient bit per cycle, one-cycle write strobe to HI/LO.
module hilo_divider
    import hilo_divider_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             Busy,
    output logic [width-1:0] Quotient,
    output logic [width-1:0] Remainder,
    output logic             WriteEnable
);

    localparam int unsigned CW = $clog2(width);

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    logic             signed_l;
    logic             sign_a;
    logic             sign_b;
    logic             zero_div;
    logic [width-1:0] a_orig;
    logic [width-1:0] b_mag;
    logic [width-1:0] rem;
    logic [width-1:0] quo;
    logic [width-1:0] rem_next;
    logic [width-1:0] quo_next;
    logic [width-1:0] q_fix;
    logic [width-1:0] r_fix;
    logic             last;

    assign last = (count == CW'(width - 1));

    hilo_divider_div_step #(.width(width)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (b_mag),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        Busy        = 1'b0;
        WriteEnable = 1'b0;
        case (state)
            IDLE: if (Start) state_next = RUN;
            RUN: begin
                Busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                WriteEnable = 1'b1;
                state_next  = Start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Final fix-up applied to the last iteration's magnitudes as they are registered.
    always_comb begin
        q_fix = quo_next;
        r_fix = rem_next;
        if (zero_div) begin
            q_fix = '1;
            r_fix = a_orig;
        end else if (signed_l) begin
            q_fix = (sign_a ^ sign_b) ? -quo_next : quo_next;
            r_fix = sign_a ? -rem_next : rem_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count     <= '0;
            signed_l  <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            zero_div  <= 1'b0;
            a_orig    <= '0;
            b_mag     <= '0;
            rem       <= '0;
            quo       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        signed_l <= Signed;
                        sign_a   <= A[width-1];
                        sign_b   <= B[width-1];
                        zero_div <= (B == '0);
                        a_orig   <= A;
                        quo      <= (Signed && A[width-1]) ? -A : A;
                        b_mag    <= (Signed && B[width-1]) ? -B : B;
                        rem      <= '0;
                        count    <= '0;
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (last) begin
                        Quotient  <= q_fix;
                        Remainder <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: arithmetic reference model, per-cycle compare, directed and random operations.
module tb_hilo_divider;

    localparam int unsigned W = 32;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         WriteEnable;

    always #5 Clock = ~Clock;

    hilo_divider #(.width(W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Signed      (Signed),
        .A           (A),
        .B           (B),
        .Busy        (Busy),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .WriteEnable (WriteEnable)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics in plain arithmetic, returns {quotient, remainder}.
    function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] min_v;
        logic [W-1:0] q;
        logic [W-1:0] r;
        min_v = {1'b1, {(W-1){1'b0}}};
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == min_v && b == '1) begin
            q = min_v;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    logic [2*W-1:0] ref_qr;
    always_comb ref_qr = ref_div(Signed, A, B);

    // Timing model: an accepted request keeps the unit busy for W cycles, then one strobe cycle.
    int           busy_left = 0;
    bit           in_done   = 1'b0;
    logic [W-1:0] held_q    = '0;
    logic [W-1:0] held_r    = '0;
    logic [W-1:0] pend_q    = '0;
    logic [W-1:0] pend_r    = '0;

    always @(posedge Clock) begin
        if (Reset) begin
            busy_left <= 0;
            in_done   <= 1'b0;
            held_q    <= '0;
            held_r    <= '0;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            in_done   <= (busy_left == 1);
            if (busy_left == 1) begin
                held_q <= pend_q;
                held_r <= pend_r;
            end
        end else begin
            in_done <= 1'b0;
            if (Start) begin
                pend_q    <= ref_qr[2*W-1:W];
                pend_r    <= ref_qr[W-1:0];
                busy_left <= W;
            end
        end
    end

    always @(negedge Clock) begin
        if (checking) begin
            check("busy", W'(Busy), W'(busy_left > 0));
            check("write_enable", W'(WriteEnable), W'(in_done));
            check("quotient", Quotient, held_q);
            check("remainder", Remainder, held_r);
        end
    end

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit lit, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input bit noise);
        int n;
        bit seen;
        @(posedge Clock); #1;
        Start = 1'b1; Signed = s; A = a; B = b;
        @(posedge Clock); #1;
        Start = 1'b0; A = $urandom; B = $urandom; Signed = 1'($urandom);
        n = 0;
        seen = 1'b0;
        while (!seen && n < int'(W) + 8) begin
            @(negedge Clock);
            n++;
            if (noise && n == 5) begin
                Start = 1'b1; A = $urandom; B = $urandom_range(1, 9); Signed = 1'($urandom);
            end
            if (noise && n == 7) Start = 1'b0;
            if (WriteEnable) seen = 1'b1;
        end
        check("we_latency", W'(n), W'(W + 1));
        if (lit) begin
            check("lit_quotient", Quotient, eq);
            check("lit_remainder", Remainder, er);
        end
    endtask

    initial begin
        int n;
        int first;
        int second;
        int we_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
        @(posedge Clock); #1;
        checking = 1'b1;
        @(posedge Clock); #1;
        check("reset_busy", W'(Busy), '0);
        check("reset_we", W'(WriteEnable), '0);
        check("reset_q", Quotient, '0);
        check("reset_r", Remainder, '0);
        Reset = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
        run_op(1'b0, 32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        run_op(1'b1, 32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
        run_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b1);

        // Back-to-back: Start held through RUN (ignored) and DONE (accepted).
        @(posedge Clock); #1;
        Start = 1'b1; Signed = 1'b0; A = 32'd100; B = 32'd7;
        @(posedge Clock); #1;
        A = 32'd1000; B = 32'd10;
        n = 0; first = 0; second = 0;
        while (second == 0 && n < 2 * int'(W) + 10) begin
            @(negedge Clock);
            n++;
            if (first != 0 && n == first + 1) Start = 1'b0;
            if (WriteEnable) begin
                if (first == 0) begin
                    first = n;
                    check("b2b_first_q", Quotient, 32'd14);
                    check("b2b_first_r", Remainder, 32'd2);
                end else begin
                    second = n;
                    check("b2b_second_q", Quotient, 32'd100);
                    check("b2b_second_r", Remainder, 32'd0);
                end
            end
        end
        Start = 1'b0;
        check("b2b_first_latency", W'(first), W'(W + 1));
        check("b2b_gap", W'(second - first), W'(W + 1));

        // Reset at iteration 10, with a Start in the same cycle that must be dropped.
        @(posedge Clock); #1;
        Start = 1'b1; Signed = 1'b0; A = 32'd100; B = 32'd7;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clock);
        #1;
        Reset = 1'b1; Start = 1'b1; A = 32'd9; B = 32'd3;
        @(posedge Clock); #1;
        Reset = 1'b0; Start = 1'b0;
        @(negedge Clock);
        check("midreset_busy", W'(Busy), '0);
        check("midreset_q", Quotient, '0);
        check("midreset_r", Remainder, '0);
        we_cnt = 0;
        repeat (int'(W) + 8) begin
            @(negedge Clock);
            if (WriteEnable) we_cnt++;
        end
        check("midreset_no_we", W'(we_cnt), '0);
        run_op(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = 32'h80000000;
                1:       ra = 32'($signed(-$urandom_range(1, 50)));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = $urandom_range(1, 15);
                3:       rb = 32'($signed(-$urandom_range(1, 15)));
                default: rb = $urandom;
            endcase
            run_op(1'($urandom), ra, rb, 1'b0, '0, '0, 1'($urandom));
        end

        repeat (3) @(posedge Clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
